// File: rtl/reg_commit_sched.sv
// reg_commit_sched: buffers up to two in-order ROB commits per cycle and retires them one per cycle
// to the register file; a ROB rollback drains the buffer first. Define REG_COMMIT_BYPASS_EN for lane-0 bypass.
module reg_commit_sched #(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 32,
   parameter int ROB_ID_W   = 4,
   parameter int REG_POS_W  = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 commit0_sign_from_rob,
   input  logic [REG_POS_W-1:0] commit0_rd_from_rob,
   input  logic [DATA_W-1:0]    commit0_V_from_rob,
   input  logic [ROB_ID_W-1:0]  commit0_Q_from_rob,
   input  logic                 commit1_sign_from_rob,
   input  logic [REG_POS_W-1:0] commit1_rd_from_rob,
   input  logic [DATA_W-1:0]    commit1_V_from_rob,
   input  logic [ROB_ID_W-1:0]  commit1_Q_from_rob,
   output logic                 commit_ready_to_rob,
   input  logic                 rollback_sign_from_rob,
   output logic                 rollback_busy_to_cmd,
   output logic                 commit_sign_to_reg,
   output logic [REG_POS_W-1:0] rd_to_reg,
   output logic [DATA_W-1:0]    V_to_reg,
   output logic [ROB_ID_W-1:0]  Q_to_reg,
   output logic                 rollback_sign_to_reg
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_ROLLBACK} state_t;

   typedef struct packed {
      logic [REG_POS_W-1:0] rd;
      logic [DATA_W-1:0]    v;
      logic [ROB_ID_W-1:0]  q;
   } entry_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   entry_t           mem_q [FIFO_DEPTH];

   entry_t           lane0, lane1, head_entry;
   logic             acc0, acc1, store0, store1, bypass, deq;
   logic [1:0]       enq_n;
   logic [PTR_W-1:0] wr1_idx;

   assign lane0      = '{rd: commit0_rd_from_rob, v: commit0_V_from_rob, q: commit0_Q_from_rob};
   assign lane1      = '{rd: commit1_rd_from_rob, v: commit1_V_from_rob, q: commit1_Q_from_rob};
   assign head_entry = mem_q[head_q];

   assign commit_ready_to_rob = (state_q == S_IDLE) && (count_q <= CNT_W'(FIFO_DEPTH - 2));

   // Lane 1 without lane 0 breaks in-order commit and is dropped.
   assign acc0 = commit0_sign_from_rob && commit_ready_to_rob;
   assign acc1 = commit1_sign_from_rob && commit0_sign_from_rob && commit_ready_to_rob;

`ifdef REG_COMMIT_BYPASS_EN
   assign bypass = (state_q == S_IDLE) && (count_q == '0) && acc0 && (commit0_rd_from_rob != '0);
`else
   assign bypass = 1'b0;
`endif

   assign store0  = acc0 && (commit0_rd_from_rob != '0) && !bypass;
   assign store1  = acc1 && (commit1_rd_from_rob != '0);
   assign enq_n   = {1'b0, store0} + {1'b0, store1};
   assign wr1_idx = tail_q + PTR_W'(store0);
   assign deq     = (count_q != '0) && (state_q != S_ROLLBACK);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      head_d  = head_q + PTR_W'(deq);
      tail_d  = tail_q + PTR_W'(enq_n);
      count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:     if (rollback_sign_from_rob) state_d = (count_d != '0) ? S_DRAIN : S_ROLLBACK;
         S_DRAIN:    if (count_d == '0) state_d = S_ROLLBACK;
         S_ROLLBACK: state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      commit_sign_to_reg = 1'b0;
      rd_to_reg          = '0;
      V_to_reg           = '0;
      Q_to_reg           = '0;
      if (bypass) begin
         commit_sign_to_reg = 1'b1;
         rd_to_reg          = lane0.rd;
         V_to_reg           = lane0.v;
         Q_to_reg           = lane0.q;
      end else if (deq) begin
         commit_sign_to_reg = 1'b1;
         rd_to_reg          = head_entry.rd;
         V_to_reg           = head_entry.v;
         Q_to_reg           = head_entry.q;
      end
   end

   assign rollback_sign_to_reg = (state_q == S_ROLLBACK);
   assign rollback_busy_to_cmd = (state_q != S_IDLE) || rollback_sign_from_rob;

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // NOTE: buffer storage is deliberately not reset; count_q alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (store0) mem_q[tail_q] <= lane0;
      if (store1) mem_q[wr1_idx] <= lane1;
   end

endmodule

// File: tb/tb_reg_commit_sched.sv
// Randomized and directed bench for reg_commit_sched: a transaction-level model predicts the
// register-file event stream; a negedge monitor pops and compares every strobe.
module tb_reg_commit_sched;

   localparam int DEPTH = 4;
`ifdef REG_COMMIT_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        c0_sign, c1_sign, rb_in;
   logic [4:0]  c0_rd, c1_rd;
   logic [31:0] c0_v, c1_v;
   logic [3:0]  c0_q, c1_q;
   logic        ready, busy, cm_sign, rb_sign;
   logic [4:0]  rd_out;
   logic [31:0] v_out;
   logic [3:0]  q_out;

   reg_commit_sched #(.FIFO_DEPTH(DEPTH), .DATA_W(32), .ROB_ID_W(4), .REG_POS_W(5)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .commit0_sign_from_rob  (c0_sign),
      .commit0_rd_from_rob    (c0_rd),
      .commit0_V_from_rob     (c0_v),
      .commit0_Q_from_rob     (c0_q),
      .commit1_sign_from_rob  (c1_sign),
      .commit1_rd_from_rob    (c1_rd),
      .commit1_V_from_rob     (c1_v),
      .commit1_Q_from_rob     (c1_q),
      .commit_ready_to_rob    (ready),
      .rollback_sign_from_rob (rb_in),
      .rollback_busy_to_cmd   (busy),
      .commit_sign_to_reg     (cm_sign),
      .rd_to_reg              (rd_out),
      .V_to_reg               (v_out),
      .Q_to_reg               (q_out),
      .rollback_sign_to_reg   (rb_sign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rb;
      logic [4:0]  rd;
      logic [31:0] v;
      logic [3:0]  q;
   } ev_t;

   typedef enum int {M_IDLE, M_DRAIN, M_RB} mmode_t;

   ev_t    exp_q[$];
   int     n_checks = 0;
   int     n_fail   = 0;
   int     m_occ    = 0;
   mmode_t m_mode   = M_IDLE;
   bit     in_reset = 1'b1;
   int     n_commit_pushed = 0;
   int     n_commit_seen   = 0;
   int     n_rb_seen       = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Register-file event monitor: each strobe must match the next predicted event.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (!in_reset) begin
            if (cm_sign) begin
               n_commit_seen++;
               if (exp_q.size() != 0) e = exp_q.pop_front();
               else e = '{rb: 1'b1, rd: '0, v: '0, q: '0};
               check("commit_is_expected", 64'(e.rb), 64'(0));
               check("commit_rd", 64'(rd_out), 64'(e.rd));
               check("commit_V", 64'(v_out), 64'(e.v));
               check("commit_Q", 64'(q_out), 64'(e.q));
            end else begin
               check("idle_payload_zero", 64'({rd_out, v_out, q_out}), 64'(0));
            end
            if (rb_sign) begin
               n_rb_seen++;
               if (exp_q.size() != 0) e = exp_q.pop_front();
               else e = '{rb: 1'b0, rd: '0, v: '0, q: '0};
               check("rollback_is_expected", 64'(e.rb), 64'(1));
            end
         end
      end
   end

   task automatic clear_inputs();
      c0_sign = 0; c0_rd = '0; c0_v = '0; c0_q = '0;
      c1_sign = 0; c1_rd = '0; c1_v = '0; c1_q = '0;
      rb_in   = 0;
   endtask

   // One clock cycle of stimulus plus the model's view of what must happen in it.
   task automatic step(input bit c0, input logic [4:0] rd0, input logic [31:0] v0, input logic [3:0] q0,
                       input bit c1, input logic [4:0] rd1, input logic [31:0] v1, input logic [3:0] q1,
                       input bit rb);
      bit m_ready, a0, a1, byp, pop;
      int enq;
      @(posedge clk); #1;
      c0_sign = c0; c0_rd = rd0; c0_v = v0; c0_q = q0;
      c1_sign = c1; c1_rd = rd1; c1_v = v1; c1_q = q1;
      rb_in   = rb;
      #1;
      m_ready = (m_mode == M_IDLE) && (DEPTH - m_occ >= 2);
      a0      = c0 && m_ready;
      a1      = c1 && c0 && m_ready;
      byp     = BYP && (m_mode == M_IDLE) && (m_occ == 0) && a0 && (rd0 != '0);
      pop     = (m_occ > 0) && (m_mode != M_RB);
      check("ready", 64'(ready), 64'(m_ready));
      check("busy", 64'(busy), 64'((rb && m_mode == M_IDLE) || (m_mode != M_IDLE)));
      check("commit_strobe", 64'(cm_sign), 64'(pop || byp));
      check("rollback_strobe", 64'(rb_sign), 64'(m_mode == M_RB));
      if (a0 && rd0 != '0) begin
         exp_q.push_back('{rb: 1'b0, rd: rd0, v: v0, q: q0});
         n_commit_pushed++;
      end
      if (a1 && rd1 != '0) begin
         exp_q.push_back('{rb: 1'b0, rd: rd1, v: v1, q: q1});
         n_commit_pushed++;
      end
      enq   = int'(a0 && rd0 != '0 && !byp) + int'(a1 && rd1 != '0);
      m_occ = m_occ + enq - int'(pop);
      case (m_mode)
         M_IDLE: if (rb) begin
            exp_q.push_back('{rb: 1'b1, rd: '0, v: '0, q: '0});
            m_mode = (m_occ != 0) ? M_DRAIN : M_RB;
         end
         M_DRAIN: if (m_occ == 0) m_mode = M_RB;
         default: m_mode = M_IDLE;
      endcase
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, '0, '0, '0, 0);
   endtask

   task automatic dual(input int tag);
      step(1, 5'(2 * tag + 1), 32'hA000_0000 + 32'(tag), 4'(tag),
           1, 5'(2 * tag + 2), 32'hB000_0000 + 32'(tag), 4'(tag + 8), 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      in_reset = 1'b1;
      rst      = 1'b1;
      clear_inputs();
      @(posedge clk); #2;
      check("rst_commit_strobe", 64'(cm_sign), 64'(0));
      check("rst_rollback_strobe", 64'(rb_sign), 64'(0));
      check("rst_ready", 64'(ready), 64'(1));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_payload", 64'({rd_out, v_out, q_out}), 64'(0));
      rst = 1'b0;
      exp_q.delete();
      m_occ    = 0;
      m_mode   = M_IDLE;
      in_reset = 1'b0;
   endtask

   initial begin
      int seen0, rb0, pushed;
      rst = 1'b1;
      clear_inputs();
      do_reset();

      // Single commit into an empty buffer.
      step(1, 5'd5, 32'h1234, 4'd3, 0, '0, '0, '0, 0);
      idle(2);

      // Back-to-back dual commits: ready must drop, order must hold.
      for (int i = 0; i < 4; i++) dual(i);
      idle(6);

      // rd = 0 on both lanes is accepted but never written.
      seen0 = n_commit_seen;
      step(1, 5'd0, 32'hDEAD, 4'd1, 1, 5'd0, 32'hBEEF, 4'd2, 0);
      idle(2);
      check("rd0_no_write", 64'(n_commit_seen - seen0), 64'(0));

      // Fill the buffer, then rollback together with a new lane-0 commit.
      dual(5);
      seen0 = n_commit_seen;
      rb0   = n_rb_seen;
      step(1, 5'd17, 32'h5555_AAAA, 4'd7, 0, '0, '0, '0, 1);
      pushed = n_commit_pushed;
      idle(8);
      check("flush_commit_count", 64'(n_commit_seen - seen0), 64'(pushed - seen0));
      check("flush_single_rollback", 64'(n_rb_seen - rb0), 64'(1));

      // Rollback on an empty buffer, then a repeated pulse during DRAIN.
      rb0 = n_rb_seen;
      step(0, '0, '0, '0, 0, '0, '0, '0, 1);
      idle(2);
      dual(6);
      dual(7);
      step(0, '0, '0, '0, 0, '0, '0, '0, 1);
      step(0, '0, '0, '0, 0, '0, '0, '0, 1);
      idle(6);
      check("rollback_count", 64'(n_rb_seen - rb0), 64'(2));

      // Reset while draining.
      dual(8);
      dual(9);
      step(0, '0, '0, '0, 0, '0, '0, '0, 1);
      do_reset();
      seen0 = n_commit_seen;
      rb0   = n_rb_seen;
      idle(3);
      check("post_reset_no_commit", 64'(n_commit_seen - seen0), 64'(0));
      check("post_reset_no_rollback", 64'(n_rb_seen - rb0), 64'(0));

      // Randomized traffic including lane-1-only violations and rollback bursts.
      for (int i = 0; i < 400; i++) begin
         logic [4:0] r0, r1;
         r0 = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
         r1 = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
         step(1'($urandom_range(1, 0)), r0, 32'($urandom), 4'($urandom_range(15, 0)),
              1'($urandom_range(1, 0)), r1, 32'($urandom), 4'($urandom_range(15, 0)),
              ($urandom_range(15, 0) == 0));
      end
      idle(10);
      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
